// File: rtl/term_streamer_if.sv
// Vector-in / beat-out stream bundle for term_streamer.
// slave is the streamer side, master is the source/sink side.
interface term_streamer_if #(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = 16
);
    localparam int IW = $clog2(NUM_ELEMENTS);

    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] in_terms [NUM_ELEMENTS];
    logic               out_valid;
    logic               out_ready;
    logic [BIT_LEN-1:0] out_term;
    logic [IW-1:0]      out_index;
    logic               out_last;
    logic [BIT_LEN-1:0] out_sum;

    modport slave (
        input  in_valid, in_terms, out_ready,
        output in_ready, out_valid, out_term,
        output out_index, out_last, out_sum
    );

    modport master (
        output in_valid, in_terms, out_ready,
        input  in_ready, out_valid, out_term,
        input  out_index, out_last, out_sum
    );
endinterface

// File: rtl/term_streamer.sv
// Serialises a captured vector of terms into one beat per cycle,
// optionally skipping zero terms, with the wrapped vector sum attached.
module term_streamer #(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = 16,
    parameter int ZERO_SKIP    = 0
) (
    input  logic           clk,
    input  logic           rst,
    term_streamer_if.slave bus
);
    localparam int IW = $clog2(NUM_ELEMENTS);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_q, state_d;
    logic [BIT_LEN-1:0] terms_q [NUM_ELEMENTS];
    logic [BIT_LEN-1:0] sum_q;
    logic [IW-1:0]      idx_q;

    logic [BIT_LEN-1:0] in_sum;
    logic [IW-1:0]      first_idx;
    logic [IW-1:0]      nxt_idx;
    logic               last_c;
    logic               fire;
    logic               accept;
    logic               ready_c;

    // Lowest emitted index of the incoming vector; N-1 if nothing qualifies.
    always_comb begin
        in_sum    = '0;
        first_idx = IW'(NUM_ELEMENTS - 1);
        for (int i = 0; i < NUM_ELEMENTS; i++)
            in_sum = in_sum + bus.in_terms[i];
        for (int i = NUM_ELEMENTS - 1; i >= 0; i--)
            if (ZERO_SKIP == 0 || bus.in_terms[i] != '0)
                first_idx = IW'(i);
    end

    // Next emitted index above the current one; none found means last beat.
    always_comb begin
        nxt_idx = idx_q;
        last_c  = 1'b1;
        for (int i = NUM_ELEMENTS - 1; i >= 0; i--)
            if (i > int'(idx_q) &&
                (ZERO_SKIP == 0 || terms_q[i] != '0)) begin
                nxt_idx = IW'(i);
                last_c  = 1'b0;
            end
    end

    always_comb begin
        state_d = state_q;
        fire    = (state_q == STREAM) & bus.out_ready;
        ready_c = (state_q == IDLE) | (fire & last_c);
        accept  = bus.in_valid & ready_c;
        unique case (state_q)
            IDLE:   if (accept) state_d = STREAM;
            STREAM: if (fire & last_c & !accept) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            terms_q <= '{default: '0};
            sum_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                terms_q <= bus.in_terms;
                sum_q   <= in_sum;
                idx_q   <= first_idx;
            end else if (fire) begin
                idx_q <= nxt_idx;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = (state_q == STREAM);
    assign bus.out_term  = terms_q[idx_q];
    assign bus.out_index = idx_q;
    assign bus.out_last  = (state_q == STREAM) & last_c;
    assign bus.out_sum   = sum_q;
endmodule
